// File: rtl/sensor_poll_scheduler.sv
// ---------------------------------------------------------------------------
// sensor_poll_scheduler
//
// Sits in front of the sensor crossbar's command port. Two command sources
// share it: a one-deep slot filled from the host UART, and (optionally) a
// periodic poll timer that alternates 'T' (8'h54) and 'D' (8'h44). The block
// issues one command at a time as a single-cycle strobe. It follows the
// command through the crossbar's ready_to_act handshake and reports either
// completion or a timeout.
//
// Build option:
//   SCHED_AUTO_POLL_EN  defined   -> periodic poll timer present
//                       undefined -> no timer, auto_en ignored, owner == 0
//
// Parameters:
//   POLL_PERIOD     auto-poll interval in clk cycles (>= 2)
//   ACCEPT_TIMEOUT  max cycles waiting for the crossbar to take a command
//   DONE_TIMEOUT    max cycles from acceptance to completion
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   host_cmd/_valid/_ready    host byte stream into the one-deep slot
//   host_cmd_reject           pulse: sampled host byte was not 'T'/'D'
//   auto_en                   enables periodic polling
//   xbar_ready_to_act         crossbar idle indicator
//   xbar_cmd, xbar_cmd_valid  command byte (held) and its one-cycle strobe
//   busy                      FSM outside IDLE
//   owner                     source of current/last command (1 = auto)
//   cmd_done, timeout_err     one-cycle completion / timeout pulses
// ---------------------------------------------------------------------------
module sensor_poll_scheduler #(
    parameter int POLL_PERIOD    = 100_000_000,
    parameter int ACCEPT_TIMEOUT = 16,
    parameter int DONE_TIMEOUT   = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] host_cmd,
    input  logic       host_cmd_valid,
    output logic       host_cmd_ready,
    output logic       host_cmd_reject,
    input  logic       auto_en,
    input  logic       xbar_ready_to_act,
    output logic [7:0] xbar_cmd,
    output logic       xbar_cmd_valid,
    output logic       busy,
    output logic       owner,
    output logic       cmd_done,
    output logic       timeout_err
);

    localparam logic [7:0] CMD_T = 8'h54;
    localparam logic [7:0] CMD_D = 8'h44;

    // One counter serves both wait states, so size it for the larger limit.
    localparam int TO_MAX = (ACCEPT_TIMEOUT > DONE_TIMEOUT) ? ACCEPT_TIMEOUT : DONE_TIMEOUT;
    localparam int TW     = $clog2(TO_MAX + 1);
    localparam logic [TW-1:0] ACC_LAST  = TW'(ACCEPT_TIMEOUT - 1);
    localparam logic [TW-1:0] DONE_LAST = TW'(DONE_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACCEPT,
        WAIT_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   to_cnt;
    logic            grant_host, grant_auto;
    logic            fire_done, fire_to, to_clr;

    logic            slot_full;
    logic [7:0]      slot_byte;
    logic            host_take, host_ok;

    logic            auto_due;
    logic [7:0]      next_auto;

    // ---------------- host slot ----------------
    assign host_take      = host_cmd_valid && !slot_full;
    assign host_ok        = (host_cmd == CMD_T) || (host_cmd == CMD_D);
    assign host_cmd_ready = !slot_full;

    // Fill and drain cannot coincide: fill needs an empty slot, grant a full one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_full       <= 1'b0;
            slot_byte       <= 8'h00;
            host_cmd_reject <= 1'b0;
        end else begin
            host_cmd_reject <= host_take && !host_ok;
            if (grant_host) begin
                slot_full <= 1'b0;
            end else if (host_take && host_ok) begin
                slot_full <= 1'b1;
                slot_byte <= host_cmd;
            end
        end
    end

    // ---------------- auto poll timer ----------------
`ifdef SCHED_AUTO_POLL_EN
    localparam int PW = $clog2(POLL_PERIOD);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_PERIOD - 1);

    logic [PW-1:0] poll_cnt;
    logic          next_is_d;

    assign next_auto = next_is_d ? CMD_D : CMD_T;

    // A fresh expiry on the grant edge wins over the grant's clear, so a
    // period is never silently dropped while the previous one issues.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            poll_cnt  <= '0;
            auto_due  <= 1'b0;
            next_is_d <= 1'b0;
        end else begin
            if (!auto_en) begin
                poll_cnt <= '0;
                auto_due <= 1'b0;
            end else if (poll_cnt == POLL_LAST) begin
                poll_cnt <= '0;
                auto_due <= 1'b1;
            end else begin
                poll_cnt <= poll_cnt + PW'(1);
                if (grant_auto)
                    auto_due <= 1'b0;
            end
            // Toggles on issue, so a command that later times out still counts.
            if (grant_auto)
                next_is_d <= !next_is_d;
        end
    end
`else
    logic unused_cfg;

    assign auto_due   = 1'b0;
    assign next_auto  = CMD_T;
    assign unused_cfg = auto_en ^ (POLL_PERIOD < 2);
`endif

    // ---------------- command FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        grant_host = 1'b0;
        grant_auto = 1'b0;
        fire_done  = 1'b0;
        fire_to    = 1'b0;
        to_clr     = 1'b0;
        case (state_q)
            IDLE: begin
                to_clr = 1'b1;
                if (xbar_ready_to_act) begin
                    if (slot_full)
                        grant_host = 1'b1;
                    else if (auto_due)
                        grant_auto = 1'b1;
                    if (slot_full || auto_due)
                        state_d = WAIT_ACCEPT;
                end
            end
            WAIT_ACCEPT: begin
                // Crossbar going busy is acceptance, even on the last cycle.
                if (!xbar_ready_to_act) begin
                    state_d = WAIT_DONE;
                    to_clr  = 1'b1;
                end else if (to_cnt == ACC_LAST) begin
                    state_d = IDLE;
                    fire_to = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (xbar_ready_to_act) begin
                    state_d   = IDLE;
                    fire_done = 1'b1;
                end else if (to_cnt == DONE_LAST) begin
                    state_d = IDLE;
                    fire_to = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Counts cycles spent in the current wait state; zero on entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            to_cnt <= '0;
        else if (to_clr || state_d == IDLE)
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + TW'(1);
    end

    // ---------------- registered outputs ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            xbar_cmd       <= 8'h00;
            xbar_cmd_valid <= 1'b0;
            owner          <= 1'b0;
            cmd_done       <= 1'b0;
            timeout_err    <= 1'b0;
        end else begin
            xbar_cmd_valid <= grant_host || grant_auto;
            cmd_done       <= fire_done;
            timeout_err    <= fire_to;
            if (grant_host) begin
                xbar_cmd <= slot_byte;
                owner    <= 1'b0;
            end else if (grant_auto) begin
                xbar_cmd <= next_auto;
                owner    <= 1'b1;
            end
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_sensor_poll_scheduler.sv
// Directed bench for sensor_poll_scheduler. Expected strobes are queued as
// stimulus is driven; a monitor pops and compares them on each strobe.
module tb_sensor_poll_scheduler;

    logic       clk;
    logic       rst;
    logic [7:0] host_cmd;
    logic       host_cmd_valid;
    logic       host_cmd_ready;
    logic       host_cmd_reject;
    logic       auto_en;
    logic       xbar_ready_to_act;
    logic [7:0] xbar_cmd;
    logic       xbar_cmd_valid;
    logic       busy;
    logic       owner;
    logic       cmd_done;
    logic       timeout_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] cmd;
        logic       own;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    logic prev_valid = 1'b0;

    sensor_poll_scheduler #(
        .POLL_PERIOD   (50),
        .ACCEPT_TIMEOUT(16),
        .DONE_TIMEOUT  (100)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .host_cmd         (host_cmd),
        .host_cmd_valid   (host_cmd_valid),
        .host_cmd_ready   (host_cmd_ready),
        .host_cmd_reject  (host_cmd_reject),
        .auto_en          (auto_en),
        .xbar_ready_to_act(xbar_ready_to_act),
        .xbar_cmd         (xbar_cmd),
        .xbar_cmd_valid   (xbar_cmd_valid),
        .busy             (busy),
        .owner            (owner),
        .cmd_done         (cmd_done),
        .timeout_err      (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic expect_cmd(input logic [7:0] c, input logic o);
        exp_t t;
        t.cmd = c;
        t.own = o;
        exp_q.push_back(t);
    endtask

    task automatic send_host(input logic [7:0] c);
        host_cmd       = c;
        host_cmd_valid = 1'b1;
        tick();
        host_cmd_valid = 1'b0;
    endtask

    task automatic wait_strobe(input string tag, input int limit, output int n);
        n = 0;
        while (!xbar_cmd_valid && n < limit) begin
            tick();
            n++;
        end
        chk(tag, xbar_cmd_valid, 1);
    endtask

    // Crossbar takes the command at the strobe, stays busy `hold` cycles.
    task automatic serve(input string tag, input int hold);
        int n;
        xbar_ready_to_act = 1'b0;
        repeat (hold) tick();
        xbar_ready_to_act = 1'b1;
        n = 0;
        while (!cmd_done && n < 5) begin
            tick();
            n++;
        end
        chk(tag, cmd_done, 1);
        chk("done_idle", busy, 0);
        tick();
        chk("done_single_pulse", cmd_done, 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"},  host_cmd_ready, 1);
        chk({tag, "_reject"}, host_cmd_reject, 0);
        chk({tag, "_cmd"},    xbar_cmd, 8'h00);
        chk({tag, "_valid"},  xbar_cmd_valid, 0);
        chk({tag, "_busy"},   busy, 0);
        chk({tag, "_owner"},  owner, 0);
        chk({tag, "_done"},   cmd_done, 0);
        chk({tag, "_to"},     timeout_err, 0);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (xbar_cmd_valid) begin
                chk("strobe_expected", 32'(exp_q.size() != 0), 1);
                chk("strobe_not_back_to_back", prev_valid, 0);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    chk("strobe_cmd", xbar_cmd, mon_e.cmd);
                    chk("strobe_owner", owner, mon_e.own);
                end
            end
            if (cmd_done || timeout_err)
                chk("done_timeout_exclusive", cmd_done & timeout_err, 0);
            prev_valid = xbar_cmd_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int t0, t1, t2;
        rst               = 1'b0;
        host_cmd          = 8'h00;
        host_cmd_valid    = 1'b0;
        auto_en           = 1'b0;
        xbar_ready_to_act = 1'b1;
        repeat (3) tick();
        chk_reset_outputs("reset");
        rst = 1'b1;
        tick();

        // Host 'T', crossbar busy 20 cycles, single completion.
        expect_cmd(8'h54, 1'b0);
        send_host(8'h54);
        chk("slot_full_ready", host_cmd_ready, 0);
        wait_strobe("t1_strobe", 10, n);
        chk("host_latency", n, 1);
        chk("t1_busy", busy, 1);
        chk("t1_slot_drained", host_cmd_ready, 1);
        serve("t1_done", 20);
        chk("t1_no_timeout", timeout_err, 0);

        // Illegal byte is rejected, nothing issued.
        send_host(8'h41);
        chk("reject_pulse", host_cmd_reject, 1);
        chk("reject_ready", host_cmd_ready, 1);
        tick();
        chk("reject_single", host_cmd_reject, 0);
        repeat (8) tick();
        chk("reject_no_busy", busy, 0);

        // Crossbar never leaves ready: accept timeout 16 cycles after strobe.
        expect_cmd(8'h44, 1'b0);
        send_host(8'h44);
        wait_strobe("t3_strobe", 10, n);
        n = 0;
        while (!timeout_err && n < 40) begin
            tick();
            n++;
        end
        chk("accept_timeout_cycles", n, 16);
        chk("accept_timeout_idle", busy, 0);
        tick();
        chk("accept_timeout_single", timeout_err, 0);

        // Crossbar stuck low after acceptance: done timeout after 100 cycles.
        expect_cmd(8'h54, 1'b0);
        send_host(8'h54);
        wait_strobe("t4_strobe", 10, n);
        xbar_ready_to_act = 1'b0;
        n = 0;
        while (!timeout_err && n < 150) begin
            tick();
            n++;
        end
        chk("done_timeout_cycles", n, 101);
        chk("done_timeout_no_done", cmd_done, 0);
        xbar_ready_to_act = 1'b1;
        repeat (3) tick();

        // One host byte waits while busy; a further byte is ignored.
        expect_cmd(8'h54, 1'b0);
        send_host(8'h54);
        wait_strobe("t5_strobe_a", 10, n);
        xbar_ready_to_act = 1'b0;
        repeat (3) tick();
        expect_cmd(8'h44, 1'b0);
        send_host(8'h44);
        chk("busy_slot_full", host_cmd_ready, 0);
        send_host(8'h54);
        chk("busy_extra_ignored_ready", host_cmd_ready, 0);
        chk("busy_extra_no_reject", host_cmd_reject, 0);
        repeat (5) tick();
        xbar_ready_to_act = 1'b1;
        n = 0;
        while (!cmd_done && n < 5) begin
            tick();
            n++;
        end
        chk("t5_done_a", cmd_done, 1);
        wait_strobe("t5_strobe_b", 10, n);
        chk("idle_gap", n, 1);
        serve("t5_done_b", 4);
        repeat (10) tick();

        // Reset during WAIT_DONE with the slot full.
        expect_cmd(8'h54, 1'b0);
        send_host(8'h54);
        wait_strobe("t6_strobe", 10, n);
        xbar_ready_to_act = 1'b0;
        tick();
        send_host(8'h44);
        chk("t6_slot_full", host_cmd_ready, 0);
        rst = 1'b0;
        xbar_ready_to_act = 1'b1;
        tick();
        chk_reset_outputs("midreset");
        rst = 1'b1;
        repeat (10) tick();
        chk("post_reset_idle", busy, 0);
        expect_cmd(8'h44, 1'b0);
        send_host(8'h44);
        wait_strobe("t6_new_strobe", 10, n);
        serve("t6_done", 3);

`ifdef SCHED_AUTO_POLL_EN
        // Auto polling, period 50, crossbar busy 10 cycles per command.
        expect_cmd(8'h54, 1'b1);
        expect_cmd(8'h44, 1'b1);
        expect_cmd(8'h54, 1'b1);
        auto_en = 1'b1;
        wait_strobe("auto_s1", 60, t0);
        chk("auto_first_delay", t0, 51);
        serve("auto_d1", 10);
        wait_strobe("auto_s2", 60, t1);
        serve("auto_d2", 10);
        wait_strobe("auto_s3", 60, t2);
        serve("auto_d3", 10);
        auto_en = 1'b0;
        // serve() takes 12 ticks after each strobe.
        chk("auto_spacing_1", t1 + 12, 50);
        chk("auto_spacing_2", t2 + 12, 50);

        // Host byte and expiry on the same edge: host first, auto after.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        expect_cmd(8'h44, 1'b0);
        expect_cmd(8'h54, 1'b1);
        auto_en = 1'b1;
        repeat (49) tick();
        send_host(8'h44);
        wait_strobe("tie_host", 10, n);
        chk("tie_host_latency", n, 1);
        serve("tie_host_done", 10);
        wait_strobe("tie_auto", 10, n);
        chk("tie_auto_gap", n, 0);
        serve("tie_auto_done", 10);
        auto_en = 1'b0;
`else
        // Without the timer, auto_en has no effect.
        auto_en = 1'b1;
        repeat (120) tick();
        chk("no_timer_idle", busy, 0);
        chk("no_timer_owner", owner, 0);
        auto_en = 1'b0;
`endif

        repeat (5) tick();
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
